// File: rtl/h_chunk_rca_pkg.sv
// Shared types and size helpers for the chunked ripple-carry adder.
package h_chunk_rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index register is at least one bit wide, even when a single chunk covers the word.
  function automatic int idx_width(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/h_chunk_rca_if.sv
// Operand/result handshake bundle for h_chunk_rca.
interface h_chunk_rca_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, signed_mode, out_ready,
    input  in_ready, out_valid, out, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, signed_mode, out_ready,
    output in_ready, out_valid, out, ovf
  );
endinterface

// File: rtl/h_chunk_rca_rca_chunk.sv
// Half/full adder cells and the CHUNK-bit ripple-carry adder built from them.
module ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  ha u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
  ha u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

module rca_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         c_msb,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa u_fa (.x(a[i]), .y(b[i]), .ci(c[i]), .s(sum[i]), .co(c[i+1]));
  end

  // Carry into the top bit is what signed overflow detection needs.
  assign c_msb = c[W-1];
  assign cout  = c[W];
endmodule

// File: rtl/h_chunk_rca.sv
// Multi-cycle adder: adds CHUNK bits per clock through one shared rca_chunk,
// low chunk first, with a valid/ready handshake on both sides.
module h_chunk_rca
  import h_chunk_rca_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  h_chunk_rca_if.slave  bus
);
  localparam int NCH  = calc_nch(WIDTH, CHUNK);
  localparam int IDXW = idx_width(NCH);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("h_chunk_rca: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  state_t           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic             sm_q;
  logic [WIDTH:0]   out_q;
  logic             ovf_q;

  logic [CHUNK-1:0]       sum;
  logic                   c_msb, cout;
  logic [WIDTH+CHUNK-1:0] res_cat;
  logic                   last_chunk;

  // Operands shift right each cycle so the active chunk always sits at bit 0.
  rca_chunk #(.W(CHUNK)) u_rca (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .cin   (carry_q),
    .sum   (sum),
    .c_msb (c_msb),
    .cout  (cout)
  );

  // New sum bits enter at the top of the result; after NCH cycles every chunk is in place.
  assign res_cat    = {sum, out_q[WIDTH-1:0]};
  assign last_chunk = (idx_q == IDXW'(NCH - 1));

  // NOTE: every register below uses non-blocking assignment so all updates
  // see the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sm_q    <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            sm_q    <= bus.signed_mode;
            idx_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          out_q[WIDTH-1:0] <= res_cat[WIDTH+CHUNK-1:CHUNK];
          carry_q          <= cout;
          a_q              <= a_q >> CHUNK;
          b_q              <= b_q >> CHUNK;
          idx_q            <= idx_q + IDXW'(1);
          if (last_chunk) begin
            // In the last chunk the operand MSBs are the word MSBs.
            out_q[WIDTH] <= sm_q ? (a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ cout) : cout;
            ovf_q        <= sm_q & (c_msb ^ cout);
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = out_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_h_chunk_rca.sv
// Directed bench for h_chunk_rca at WIDTH=16 (CHUNK=4 main instance, CHUNK=16 single-cycle instance).
module tb_h_chunk_rca;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  h_chunk_rca_if #(.WIDTH(W)) bus  ();
  h_chunk_rca_if #(.WIDTH(W)) bus2 ();

  h_chunk_rca #(.WIDTH(W), .CHUNK(4))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  h_chunk_rca #(.WIDTH(W), .CHUNK(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sm);
    logic [W:0] ea, eb;
    ea = sm ? {a[W-1], a} : {1'b0, a};
    eb = sm ? {b[W-1], b} : {1'b0, b};
    return ea + eb + {{W{1'b0}}, cin};
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, input logic sm);
    logic [W:0] s;
    s = model_sum(a, b, cin, sm);
    return sm & (s[W] ^ s[W-1]);
  endfunction

  // Launch one operation, scramble inputs while it runs, then check latency and result.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sm, input logic [W:0] exp_out,
                       input logic exp_ovf);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin tick(); n++; end
    bus.a = a; bus.b = b; bus.cin = cin; bus.signed_mode = sm; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom);
    bus.cin = 1'($urandom); bus.signed_mode = 1'($urandom);
    n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    check({tag, "_lat"}, 32'(n), 32'd4);
    check({tag, "_out"}, 32'(bus.out), 32'(exp_out));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    total = 0;
    bad   = 0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus.signed_mode = 1'b0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
    bus2.signed_mode = 1'b0; bus2.out_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out",       32'(bus.out),       32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    rst_n = 1'b1;
    tick();

    do_op("u_ffff_1",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0);
    do_op("u_ffff_ffff",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, 1'b0);
    do_op("s_7fff_1",     16'h7FFF, 16'h0001, 1'b0, 1'b1, 17'h08000, 1'b1);
    do_op("s_8000_ffff",  16'h8000, 16'hFFFF, 1'b0, 1'b1, 17'h17FFF, 1'b1);
    do_op("s_m1_m1",      16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 17'h1FFFE, 1'b0);
    do_op("u_cin_ripple", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 17'h01000, 1'b0);

    // Backpressure: result must hold while out_ready stays low.
    bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.signed_mode = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    check("bp_lat", 32'(n), 32'd4);
    for (int i = 0; i < 5; i++) begin
      bus.a = 16'($urandom); bus.b = 16'($urandom);
      check("bp_out",       32'(bus.out),       32'h02345);
      check("bp_ovf",       32'(bus.ovf),       32'd0);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset during the second RUN cycle discards the partial result.
    bus.a = 16'h000F; bus.b = 16'h0003; bus.cin = 1'b0; bus.signed_mode = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out",       32'(bus.out),       32'd0);
    check("mid_rst_ovf",       32'(bus.ovf),       32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    #2;
    rst_n = 1'b1;
    tick();
    do_op("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 1'b0);

    // Back-to-back random operations in both modes against the reference sum.
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'(i % 2);
      do_op("rand", ra, rb, rc, rs, model_sum(ra, rb, rc, rs), model_ovf(ra, rb, rc, rs));
    end

    // CHUNK == WIDTH: a single RUN cycle.
    bus2.a = 16'h8000; bus2.b = 16'h8000; bus2.cin = 1'b0; bus2.signed_mode = 1'b1;
    bus2.in_valid = 1'b1;
    tick();
    bus2.in_valid = 1'b0;
    n = 0;
    while (!bus2.out_valid && n < 20) begin tick(); n++; end
    check("one_chunk_lat", 32'(n),         32'd1);
    check("one_chunk_out", 32'(bus2.out),  32'h10000);
    check("one_chunk_ovf", 32'(bus2.ovf),  32'd1);
    bus2.out_ready = 1'b1;
    tick();
    bus2.out_ready = 1'b0;
    check("one_chunk_idle", 32'(bus2.in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/h_chunk_rca.md
H_CHUNK_RCA -- requirements
Module: h_chunk_rca

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits.
REQ-002 Parameter CHUNK, default 8, bits added per clock cycle; WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH SHALL be enforced by an elaboration-time check.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operands present.
REQ-006 in_ready  output  1  block accepts operands.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in.
REQ-010 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out  output  WIDTH+1  sum; bit WIDTH is carry (unsigned) or sign extension (signed).
REQ-014 ovf  output  1  signed overflow of the WIDTH-bit sum; 0 in unsigned mode.

Function
REQ-015 NCH = WIDTH/CHUNK; FSM states IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Input handshake (in_valid & in_ready at a rising edge) SHALL latch a, b, cin and signed_mode, set chunk index to 0, set the carry register to cin, and go IDLE->RUN.
REQ-018 Each RUN cycle SHALL add operand chunk [idx*CHUNK +: CHUNK] of A and B plus the carry register, write the CHUNK sum bits into the result register, update the carry, and increment idx.
REQ-019 After chunk NCH-1 the FSM SHALL go RUN->DONE; out_valid rises exactly NCH cycles after the input-handshake edge.
REQ-020 out[WIDTH] SHALL equal the final carry when signed_mode=0, and a[WIDTH-1]^b[WIDTH-1]^final carry when signed_mode=1.
REQ-021 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB when signed_mode=1, and 0 otherwise.
REQ-022 In DONE, out and ovf SHALL stay stable while out_ready=0; on out_ready=1 the FSM SHALL go DONE->IDLE, with in_ready=1 on the next cycle.
REQ-023 Input changes outside an input handshake SHALL NOT affect an operation in progress.
REQ-024 For CHUNK == WIDTH, RUN SHALL last exactly one cycle.

Reset
REQ-025 Assertion of rst_n=0 in any state, including mid-RUN or DONE, SHALL immediately force IDLE, out=0, ovf=0, out_valid=0, in_ready=1, idx=0 and carry=0, and SHALL discard any partial result.
REQ-026 After rst_n deasserts, the first input handshake SHALL occur no earlier than the first rising edge.

Structure
REQ-027 A shared package SHALL hold the FSM state enum and the NCH/index-width derivation function.
REQ-028 A single sub-module, rca_chunk (CHUNK-bit ripple-carry adder built from the existing ha/fa cells, exporting carry-into-MSB and carry-out), SHALL perform the per-cycle addition.
REQ-029 The datapath SHALL instantiate exactly one rca_chunk, reused every RUN cycle.

Verification (WIDTH=16, CHUNK=4)
REQ-030 Unsigned, a=0xFFFF, b=0x0001, cin=0 -> out=0x10000, ovf=0, out_valid 4 cycles after the handshake.
REQ-031 Unsigned, a=0xFFFF, b=0xFFFF, cin=1 -> out=0x1FFFF, ovf=0.
REQ-032 Signed, a=0x7FFF, b=0x0001 -> out=0x08000, ovf=1; signed, a=0x8000, b=0xFFFF -> out=0x17FFF, ovf=1.
REQ-033 Backpressure: out_ready held low for 5 cycles in DONE -> out/ovf constant, in_ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-034 rst_n pulsed low during the 2nd RUN cycle -> outputs are immediately at reset values; the next operation a=0x1234, b=0x4321 -> out=0x05555.
REQ-035 Random back-to-back operations in both modes SHALL match a reference model a+b+cin.
